// File: rtl/alu_operand_skid_if.sv
// Handshake and operand bundle between an upstream producer, the operand
// skid buffer and the downstream four-input mux stage.
interface alu_operand_skid_if #(
  parameter int INPUT_LENGTH = 8
) ();

  // Upstream side
  logic                    in_valid;
  logic                    in_ready;
  logic [INPUT_LENGTH-1:0] in_a;
  logic [INPUT_LENGTH-1:0] in_b;
  logic [INPUT_LENGTH-1:0] in_c;
  logic [INPUT_LENGTH-1:0] in_d;
  logic [1:0]              in_sel;

  // Downstream side
  logic                    out_valid;
  logic                    out_ready;
  logic [INPUT_LENGTH-1:0] out_a;
  logic [INPUT_LENGTH-1:0] out_b;
  logic [INPUT_LENGTH-1:0] out_c;
  logic [INPUT_LENGTH-1:0] out_d;
  logic [1:0]              out_sel;

  logic [1:0]              occupancy;

  // View seen by the skid buffer itself
  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, in_sel, out_ready,
    output in_ready, out_valid, out_a, out_b, out_c, out_d, out_sel, occupancy
  );

  // View seen by the environment driving and consuming the buffer
  modport master (
    output in_valid, in_a, in_b, in_c, in_d, in_sel, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_c, out_d, out_sel, occupancy
  );

endinterface

// File: rtl/alu_operand_skid.sv
// Two-entry skid buffer registering the operand set {a, b, c, d, sel} in front
// of a four-input mux; handshake outputs are pure functions of state.
module alu_operand_skid #(
  parameter int INPUT_LENGTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  alu_operand_skid_if.slave  bus
);

  typedef struct packed {
    logic [INPUT_LENGTH-1:0] a;
    logic [INPUT_LENGTH-1:0] b;
    logic [INPUT_LENGTH-1:0] c;
    logic [INPUT_LENGTH-1:0] d;
    logic [1:0]              sel;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;

  logic in_fire;
  logic out_fire;
  logic load_main;
  logic load_skid;
  logic main_from_skid;

  assign in_entry = '{a: bus.in_a, b: bus.in_b, c: bus.in_c, d: bus.in_d, sel: bus.in_sel};

  // Handshake outputs depend on registered state only, so no combinational
  // path runs from in_valid or out_ready through this block.
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          // Main keeps its stale contents; out_valid=0 masks them.
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_from_skid = 1'b1;
          state_d        = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the operand registers are reset too, because out_sel and the
  // operands must read zero while reset is asserted, not just out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
    end else if (load_main) begin
      main_q <= in_entry;
    end else if (main_from_skid) begin
      main_q <= skid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_entry;
    end
  end

  always_comb begin
    bus.occupancy = 2'd0;
    case (state_q)
      EMPTY:   bus.occupancy = 2'd0;
      BUSY:    bus.occupancy = 2'd1;
      FULL:    bus.occupancy = 2'd2;
      default: bus.occupancy = 2'd0;
    endcase
  end

  assign bus.out_a   = main_q.a;
  assign bus.out_b   = main_q.b;
  assign bus.out_c   = main_q.c;
  assign bus.out_d   = main_q.d;
  assign bus.out_sel = main_q.sel;

endmodule

// File: doc/alu_operand_skid.md
ALU_OPERAND_SKID -- requirements
Module: alu_operand_skid

Interface
REQ-001 The block SHALL have one parameter: INPUT_LENGTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have an input port clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have an input port rst_n, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have an input port in_valid, 1 bit: the upstream producer offers an operand set.
REQ-005 The block SHALL have an output port in_ready, 1 bit: the block can accept an operand set this cycle.
REQ-006 The block SHALL have input ports in_a, in_b, in_c, in_d, each INPUT_LENGTH bits: the candidate operands.
REQ-007 The block SHALL have an input port in_sel, 2 bits: the four-input mux select travelling with the operands.
REQ-008 The block SHALL have an output port out_valid, 1 bit: an operand set is presented to the downstream mux stage.
REQ-009 The block SHALL have an input port out_ready, 1 bit: the downstream stage consumes this cycle.
REQ-010 The block SHALL have output ports out_a, out_b, out_c, out_d, each INPUT_LENGTH bits: registered operands driving mux inputs a..d.
REQ-011 The block SHALL have an output port out_sel, 2 bits: registered select driving the mux select input.
REQ-012 The block SHALL have an output port occupancy, 2 bits: number of held entries (0, 1 or 2).

Function
REQ-013 Input fire SHALL be defined as in_valid & in_ready; output fire SHALL be defined as out_valid & out_ready.
REQ-014 Storage SHALL consist of a main register and a skid register, each holding {a, b, c, d, sel}.
REQ-015 The FSM SHALL have three states: EMPTY (occupancy 0), BUSY (occupancy 1, main valid) and FULL (occupancy 2, main and skid valid).
REQ-016 Outputs SHALL be: out_valid = (state != EMPTY); in_ready = (state != FULL); out_* driven only from the main register.
REQ-017 in_ready and out_valid SHALL depend on state only, with no combinational path from in_valid or out_ready.
REQ-018 In EMPTY: input fire SHALL load main and go to BUSY; otherwise the state SHALL hold.
REQ-019 In BUSY: input and output fire together SHALL load main from the inputs and stay in BUSY.
REQ-020 In BUSY: input fire alone SHALL load skid from the inputs and go to FULL.
REQ-021 In BUSY: output fire alone SHALL go to EMPTY, and main contents SHALL be retained without clearing.
REQ-022 In FULL: output fire SHALL copy skid into main and go to BUSY; otherwise the state SHALL hold; no input is accepted.
REQ-023 Latency SHALL be one cycle: a set accepted at edge N appears on out_* with out_valid at edge N when the block was EMPTY (i.e. registered, visible after edge N).
REQ-024 Ordering SHALL be strict FIFO; no set is ever dropped or duplicated.
REQ-025 While out_valid=1 and out_ready=0, out_* and out_sel SHALL remain bit-stable.
REQ-026 Data SHALL pass through unmodified at full INPUT_LENGTH width, with no arithmetic, truncation or extension.
REQ-027 Sustained in_valid=out_ready=1 SHALL give one transfer per cycle (100% throughput).
REQ-028 Sets presented while in_ready=0 SHALL be ignored, and the block SHALL not latch them.

Reset
REQ-029 rst_n low SHALL immediately force state to EMPTY, occupancy to 0, out_valid to 0, and all main and skid fields including out_sel to 0, regardless of clk.
REQ-030 While rst_n is low, no register SHALL capture inputs; in_ready SHALL read 1 (EMPTY), but no transfer occurs.
REQ-031 Reset asserted mid-operation (BUSY or FULL) SHALL discard all held entries; the first input fire after release SHALL enter EMPTY->BUSY normally.

Verification
REQ-032 Single transfer, INPUT_LENGTH=8: send a=03, b=ff, c=0f, d=ee, sel=3 with out_ready=1 -> one cycle later out_valid=1 with the same values, then EMPTY.
REQ-033 Backpressure: out_ready=0; send sets S1 {a=03, sel=2} and S2 {a=00, sel=1} -> occupancy 1 then 2; in_ready=0; out_* stay S1; third set S3 ignored.
REQ-034 Drain from FULL: from REQ-033, set out_ready=1 -> S1 consumed, then S2 consumed, occupancy 2->1->0, in_ready rises the cycle after the first output fire.
REQ-035 Streaming: 8 sets with sel cycling 0,1,2,3 and in_valid=out_ready=1 -> 8 outputs on 8 consecutive cycles, in order, occupancy constant 1.
REQ-036 Asynchronous reset: in FULL, pulse rst_n low between clock edges -> out_valid, occupancy and out_sel go to 0 without a clock edge; next set accepted normally.
REQ-037 Random valid/ready: 1000 random sets -> scoreboard shows exact in-order match, no loss, and out_* stable whenever stalled.
